// File: rtl/mk_top_pkg.sv
// Shared constants for the mk_top RV32I multicycle core: opcodes, funct3
// codes, FSM states and request-word field positions.
package mk_top_pkg;

  localparam int ADDR_LSB  = 33;
  localparam int WRITE_BIT = 32;

  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_OP     = 7'b0110011;

  localparam logic [2:0] F3_ADD  = 3'd0;
  localparam logic [2:0] F3_SLL  = 3'd1;
  localparam logic [2:0] F3_SLT  = 3'd2;
  localparam logic [2:0] F3_SLTU = 3'd3;
  localparam logic [2:0] F3_XOR  = 3'd4;
  localparam logic [2:0] F3_SR   = 3'd5;
  localparam logic [2:0] F3_OR   = 3'd6;
  localparam logic [2:0] F3_AND  = 3'd7;

  localparam logic [2:0] F3_BEQ  = 3'd0;
  localparam logic [2:0] F3_BNE  = 3'd1;
  localparam logic [2:0] F3_BLT  = 3'd4;
  localparam logic [2:0] F3_BGE  = 3'd5;
  localparam logic [2:0] F3_BLTU = 3'd6;
  localparam logic [2:0] F3_BGEU = 3'd7;

  localparam logic [2:0] F3_B  = 3'd0;
  localparam logic [2:0] F3_H  = 3'd1;
  localparam logic [2:0] F3_BU = 3'd4;
  localparam logic [2:0] F3_HU = 3'd5;

  typedef enum logic [2:0] {
    S_FETCH_RQ, S_FETCH_WAIT, S_EXEC, S_MEM_RQ, S_MEM_WAIT, S_RMW_RQ, S_RMW_WAIT
  } state_t;

endpackage

// File: rtl/mk_top_alu.sv
// Combinational RV32I integer ALU plus branch comparator (both use a_i/b_i).
module mk_top_alu
  import mk_top_pkg::*;
(
  input  logic [31:0] a_i,
  input  logic [31:0] b_i,
  input  logic [2:0]  f3_i,
  input  logic        alt_i,
  output logic [31:0] res_o,
  output logic        br_taken_o
);

  logic signed [31:0] sra;
  assign sra = $signed(a_i) >>> b_i[4:0];

  always_comb begin
    res_o = '0;
    case (f3_i)
      F3_ADD:  res_o = alt_i ? a_i - b_i : a_i + b_i;
      F3_SLL:  res_o = a_i << b_i[4:0];
      F3_SLT:  res_o = {31'b0, $signed(a_i) < $signed(b_i)};
      F3_SLTU: res_o = {31'b0, a_i < b_i};
      F3_XOR:  res_o = a_i ^ b_i;
      F3_SR:   res_o = alt_i ? $unsigned(sra) : a_i >> b_i[4:0];
      F3_OR:   res_o = a_i | b_i;
      F3_AND:  res_o = a_i & b_i;
      default: res_o = '0;
    endcase
  end

  always_comb begin
    br_taken_o = 1'b0;
    case (f3_i)
      F3_BEQ:  br_taken_o = a_i == b_i;
      F3_BNE:  br_taken_o = a_i != b_i;
      F3_BLT:  br_taken_o = $signed(a_i) < $signed(b_i);
      F3_BGE:  br_taken_o = $signed(a_i) >= $signed(b_i);
      F3_BLTU: br_taken_o = a_i < b_i;
      F3_BGEU: br_taken_o = a_i >= b_i;
      default: br_taken_o = 1'b0;
    endcase
  end

endmodule

// File: rtl/mk_top.sv
// Minimal multicycle RV32I core with one request port (get) and one response
// port (put); one outstanding request, same-cycle responses skip the WAIT state.
module mk_top
  import mk_top_pkg::*;
(
  input  logic        CLK,
  input  logic        RST_N,
  input  logic        EN_obtain_rq_get,
  output logic [64:0] obtain_rq_get,
  output logic        RDY_obtain_rq_get,
  input  logic [31:0] send_rs_put,
  input  logic        EN_send_rs_put,
  output logic        RDY_send_rs_put
);

  state_t      state_q;
  logic        live_q;
  logic [31:0] proc_m8_pc;
  logic [31:0] ir_q;
  logic [64:0] req_q;
  logic [31:0] rf_q [32];

  logic [6:0]  opc;
  logic [4:0]  rd, rs1, rs2;
  logic [2:0]  f3;
  logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;
  logic [31:0] rs1_v, rs2_v, pc4, jalr_t;

  assign opc   = ir_q[6:0];
  assign rd    = ir_q[11:7];
  assign f3    = ir_q[14:12];
  assign rs1   = ir_q[19:15];
  assign rs2   = ir_q[24:20];
  assign imm_i = {{20{ir_q[31]}}, ir_q[31:20]};
  assign imm_s = {{20{ir_q[31]}}, ir_q[31:25], ir_q[11:7]};
  assign imm_b = {{19{ir_q[31]}}, ir_q[31], ir_q[7], ir_q[30:25], ir_q[11:8], 1'b0};
  assign imm_u = {ir_q[31:12], 12'b0};
  assign imm_j = {{11{ir_q[31]}}, ir_q[31], ir_q[19:12], ir_q[20], ir_q[30:21], 1'b0};
  assign rs1_v = rf_q[rs1];
  assign rs2_v = rf_q[rs2];
  assign pc4   = proc_m8_pc + 32'd4;
  assign jalr_t = rs1_v + imm_i;

  logic [31:0] alu_b, alu_res;
  logic        alu_alt, br_taken;

  // bit 30 selects SUB/SRA; for OP-IMM it is immediate data except on shifts
  assign alu_b   = (opc == OP_IMM) ? imm_i : rs2_v;
  assign alu_alt = ir_q[30] & ((opc == OP_OP) | (f3 == F3_SR));

  mk_top_alu u_alu (
    .a_i        (rs1_v),
    .b_i        (alu_b),
    .f3_i       (f3),
    .alt_i      (alu_alt),
    .res_o      (alu_res),
    .br_taken_o (br_taken)
  );

  logic is_rq, is_wait, resp_now;
  assign is_rq    = state_q inside {S_FETCH_RQ, S_MEM_RQ, S_RMW_RQ};
  assign is_wait  = state_q inside {S_FETCH_WAIT, S_MEM_WAIT, S_RMW_WAIT};
  assign resp_now = EN_send_rs_put & (is_wait | (is_rq & EN_obtain_rq_get));

  logic [31:0] ex_pc, ex_val, mem_addr, mem_wdata, ld_val, rmw_data, wb_val;
  logic        ex_wb, ex_mem, mem_wr, rmw_need, wb_en;

  always_comb begin
    ex_pc     = pc4;
    ex_wb     = 1'b0;
    ex_val    = alu_res;
    ex_mem    = 1'b0;
    mem_addr  = rs1_v + imm_i;
    mem_wr    = 1'b0;
    mem_wdata = '0;
    case (opc)
      OP_LUI:    begin ex_wb = 1'b1; ex_val = imm_u; end
      OP_AUIPC:  begin ex_wb = 1'b1; ex_val = proc_m8_pc + imm_u; end
      OP_JAL:    begin ex_wb = 1'b1; ex_val = pc4; ex_pc = proc_m8_pc + imm_j; end
      OP_JALR:   begin ex_wb = 1'b1; ex_val = pc4; ex_pc = {jalr_t[31:1], 1'b0}; end
      OP_BRANCH: if (br_taken) ex_pc = proc_m8_pc + imm_b;
      OP_IMM, OP_OP: ex_wb = 1'b1;
      OP_LOAD:   ex_mem = 1'b1;
      OP_STORE: begin
        ex_mem    = 1'b1;
        mem_addr  = rs1_v + imm_s;
        mem_wr    = f3[1];
        mem_wdata = f3[1] ? rs2_v : '0;
      end
      default: ;
    endcase
  end

  always_comb begin
    case (f3)
      F3_B:    ld_val = {{24{send_rs_put[7]}}, send_rs_put[7:0]};
      F3_H:    ld_val = {{16{send_rs_put[15]}}, send_rs_put[15:0]};
      F3_BU:   ld_val = {24'b0, send_rs_put[7:0]};
      F3_HU:   ld_val = {16'b0, send_rs_put[15:0]};
      default: ld_val = send_rs_put;
    endcase
  end

  // SB/SH merge the fetched word with rs2 and write it back to the same address
  assign rmw_need = (opc == OP_STORE) & ~f3[1];
  assign rmw_data = (f3 == F3_B) ? {send_rs_put[31:8], rs2_v[7:0]}
                                 : {send_rs_put[31:16], rs2_v[15:0]};

  always_comb begin
    wb_en  = 1'b0;
    wb_val = ex_val;
    if (state_q == S_EXEC) wb_en = ex_wb;
    else if ((state_q inside {S_MEM_RQ, S_MEM_WAIT}) && resp_now && opc == OP_LOAD) begin
      wb_en  = 1'b1;
      wb_val = ld_val;
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q    <= S_FETCH_RQ;
      live_q     <= 1'b0;
      proc_m8_pc <= '0;
      ir_q       <= '0;
      req_q      <= '0;
      for (int i = 0; i < 32; i++) rf_q[i] <= '0;
    end else begin
      live_q <= 1'b1;
      if (wb_en && rd != 5'd0) rf_q[rd] <= wb_val;
      case (state_q)
        S_FETCH_RQ, S_FETCH_WAIT: begin
          if (resp_now) begin
            ir_q    <= send_rs_put;
            state_q <= S_EXEC;
          end else if (is_rq && EN_obtain_rq_get) state_q <= S_FETCH_WAIT;
        end
        S_EXEC: begin
          if (ex_mem) begin
            req_q   <= {mem_addr, mem_wr, mem_wdata};
            state_q <= S_MEM_RQ;
          end else begin
            proc_m8_pc <= ex_pc;
            req_q      <= {ex_pc, 1'b0, 32'h0};
            state_q    <= S_FETCH_RQ;
          end
        end
        S_MEM_RQ, S_MEM_WAIT: begin
          if (resp_now) begin
            if (rmw_need) begin
              req_q   <= {req_q[ADDR_LSB +: 32], 1'b1, rmw_data};
              state_q <= S_RMW_RQ;
            end else begin
              proc_m8_pc <= pc4;
              req_q      <= {pc4, 1'b0, 32'h0};
              state_q    <= S_FETCH_RQ;
            end
          end else if (is_rq && EN_obtain_rq_get) state_q <= S_MEM_WAIT;
        end
        S_RMW_RQ, S_RMW_WAIT: begin
          if (resp_now) begin
            proc_m8_pc <= pc4;
            req_q      <= {pc4, 1'b0, 32'h0};
            state_q    <= S_FETCH_RQ;
          end else if (is_rq && EN_obtain_rq_get) state_q <= S_RMW_WAIT;
        end
        default: state_q <= S_FETCH_RQ;
      endcase
    end
  end

  assign obtain_rq_get     = req_q;
  assign RDY_obtain_rq_get = live_q & is_rq;
  assign RDY_send_rs_put   = live_q & (state_q != S_EXEC);

  logic unused_write_bit;
  assign unused_write_bit = req_q[WRITE_BIT];

endmodule

// File: tb/tb_mk_top.sv
// Scoreboard bench for mk_top: a byte memory model answers requests (1-cycle
// latency below 0x10000000, same-cycle above) and a monitor checks each request.
module tb_mk_top;

  logic        CLK = 1'b0;
  logic        RST_N;
  logic        EN_obtain_rq_get;
  logic [64:0] obtain_rq_get;
  logic        RDY_obtain_rq_get;
  logic [31:0] send_rs_put;
  logic        EN_send_rs_put;
  logic        RDY_send_rs_put;

  mk_top dut (
    .CLK               (CLK),
    .RST_N             (RST_N),
    .EN_obtain_rq_get  (EN_obtain_rq_get),
    .obtain_rq_get     (obtain_rq_get),
    .RDY_obtain_rq_get (RDY_obtain_rq_get),
    .send_rs_put       (send_rs_put),
    .EN_send_rs_put    (EN_send_rs_put),
    .RDY_send_rs_put   (RDY_send_rs_put)
  );

  always #5 CLK = ~CLK;

  typedef struct packed { logic [31:0] a; logic w; logic [31:0] d; } exp_t;
  exp_t exp_q[$];

  int vecs = 0, miss = 0, cyc = 0, nreq = 0;
  int acc_cyc [64];
  logic [7:0]  mem [0:4095];
  logic        pend = 1'b0;
  logic [31:0] pend_d = '0;

  always @(posedge CLK) cyc <= cyc + 1;

  function automatic logic [31:0] enc_i(logic [31:0] imm, logic [4:0] rs1, logic [2:0] f3, logic [4:0] rd, logic [6:0] op);
    return {imm[11:0], rs1, f3, rd, op};
  endfunction
  function automatic logic [31:0] enc_s(logic [31:0] imm, logic [4:0] rs2, logic [4:0] rs1, logic [2:0] f3);
    return {imm[11:5], rs2, rs1, f3, imm[4:0], 7'b0100011};
  endfunction
  function automatic logic [31:0] enc_b(logic [31:0] imm, logic [4:0] rs2, logic [4:0] rs1, logic [2:0] f3);
    return {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], 7'b1100011};
  endfunction
  function automatic logic [31:0] enc_u(logic [19:0] imm, logic [4:0] rd, logic [6:0] op);
    return {imm, rd, op};
  endfunction
  function automatic logic [31:0] enc_j(logic [31:0] imm, logic [4:0] rd);
    return {imm[20], imm[10:1], imm[11], imm[19:12], rd, 7'b1101111};
  endfunction
  function automatic logic [31:0] enc_r(logic [6:0] f7, logic [4:0] rs2, logic [4:0] rs1, logic [2:0] f3, logic [4:0] rd);
    return {f7, rs2, rs1, f3, rd, 7'b0110011};
  endfunction

  task automatic put_w(int a, logic [31:0] w);
    for (int k = 0; k < 4; k++) mem[a + k] = w[8*k +: 8];
  endtask

  function automatic logic [31:0] rd_w(logic [31:0] a);
    return {mem[a + 3], mem[a + 2], mem[a + 1], mem[a]};
  endfunction

  task automatic ex(logic [31:0] a, logic w, logic [31:0] d);
    exp_q.push_back('{a: a, w: w, d: d});
  endtask

  task automatic chk(string nm, logic [31:0] got, logic [31:0] want);
    vecs++;
    if (got !== want) begin
      miss++;
      $display("FAIL %s: got %h want %h", nm, got, want);
    end
  endtask

  task automatic wait_drain(int lim);
    for (int c = 0; c < lim && exp_q.size() != 0; c++) @(posedge CLK);
    if (exp_q.size() != 0) begin
      vecs++;
      miss++;
      $display("FAIL drain: got %0d requests outstanding want 0", exp_q.size());
      exp_q.delete();
    end
  endtask

  // Memory / MMIO model
  initial begin
    logic [31:0] a, d;
    EN_obtain_rq_get = 1'b0;
    EN_send_rs_put   = 1'b0;
    send_rs_put      = '0;
    forever begin
      @(negedge CLK);
      EN_obtain_rq_get = 1'b0;
      EN_send_rs_put   = 1'b0;
      if (pend) begin
        EN_send_rs_put = 1'b1;
        send_rs_put    = pend_d;
        pend           = 1'b0;
      end
      if (RST_N && RDY_obtain_rq_get) begin
        EN_obtain_rq_get = 1'b1;
        a = obtain_rq_get[64:33];
        d = (a >= 32'h1000_0000) ? 32'h0 : rd_w(a);
        if (obtain_rq_get[32] && a < 32'h1000_0000) put_w(int'(a), obtain_rq_get[31:0]);
        if (a >= 32'h1000_0000) begin
          EN_send_rs_put = 1'b1;
          send_rs_put    = d;
        end else begin
          pend   = 1'b1;
          pend_d = d;
        end
      end
    end
  end

  // Request monitor
  initial begin
    exp_t e;
    logic [64:0] got;
    forever begin
      @(negedge CLK);
      #1;
      if (RST_N && RDY_obtain_rq_get && EN_obtain_rq_get && exp_q.size() != 0) begin
        e   = exp_q.pop_front();
        got = obtain_rq_get;
        vecs++;
        if (got[64:33] !== e.a || got[32] !== e.w || (e.w && got[31:0] !== e.d)) begin
          miss++;
          $display("FAIL req%0d: got addr=%h wr=%b data=%h want addr=%h wr=%b data=%h",
                   nreq, got[64:33], got[32], got[31:0], e.a, e.w, e.d);
        end
        if (nreq < 64) acc_cyc[nreq] = cyc;
        nreq++;
      end
    end
  end

  initial begin
    RST_N = 1'b0;
    for (int i = 0; i < 4096; i++) mem[i] = 8'h00;
    put_w('h00, enc_i(5, 0, 0, 1, 7'h13));
    put_w('h04, enc_i(-7, 1, 0, 2, 7'h13));
    put_w('h08, enc_u(20'h10012, 3, 7'h37));
    put_w('h0C, enc_i(12, 3, 0, 3, 7'h13));
    put_w('h10, enc_u(20'h00AB0, 4, 7'h37));
    put_w('h14, enc_s(0, 4, 3, 2));
    put_w('h18, enc_i('h100, 0, 0, 5, 7'h03));
    put_w('h1C, enc_i('h100, 0, 4, 6, 7'h03));
    put_w('h20, enc_i('h101, 0, 1, 7, 7'h03));
    put_w('h24, enc_s('h300, 5, 0, 2));
    put_w('h28, enc_s('h304, 6, 0, 2));
    put_w('h2C, enc_s('h308, 7, 0, 2));
    put_w('h30, enc_i('h55, 0, 0, 8, 7'h13));
    put_w('h34, enc_s('h200, 8, 0, 0));
    put_w('h38, enc_b(8, 1, 1, 0));
    put_w('h3C, enc_i(1, 0, 0, 9, 7'h13));
    put_w('h40, enc_b(8, 1, 1, 1));
    put_w('h44, enc_j(16, 1));
    for (int a = 'h48; a <= 'h50; a += 4) put_w(a, enc_i(1, 0, 0, 9, 7'h13));
    put_w('h54, enc_i(7, 0, 0, 0, 7'h13));
    put_w('h58, enc_s('h310, 1, 0, 2));
    put_w('h5C, enc_s('h314, 0, 0, 2));
    put_w('h60, enc_s(0, 2, 3, 2));
    put_w('h64, enc_u(20'h0, 10, 7'h17));
    put_w('h68, enc_i('h10, 10, 0, 11, 7'h67));
    put_w('h6C, enc_i(1, 0, 0, 9, 7'h13));
    put_w('h70, enc_i(1, 0, 0, 9, 7'h13));
    put_w('h74, enc_r(7'h20, 2, 1, 0, 12));
    put_w('h78, enc_s('h318, 10, 0, 2));
    put_w('h7C, enc_s('h31C, 11, 0, 2));
    put_w('h80, enc_s('h320, 12, 0, 2));
    put_w('h84, enc_j(0, 0));
    mem['h100] = 8'hF0; mem['h101] = 8'h34; mem['h102] = 8'h82; mem['h103] = 8'h00;
    put_w('h200, 32'h1122_3344);

    ex('h00, 0, 0); ex('h04, 0, 0); ex('h08, 0, 0); ex('h0C, 0, 0);
    ex('h10, 0, 0); ex('h14, 0, 0); ex(32'h1001200c, 1, 32'h00AB0000);
    ex('h18, 0, 0); ex('h100, 0, 0); ex('h1C, 0, 0); ex('h100, 0, 0);
    ex('h20, 0, 0); ex('h101, 0, 0);
    ex('h24, 0, 0); ex('h300, 1, 32'hFFFF_FFF0);
    ex('h28, 0, 0); ex('h304, 1, 32'h0000_00F0);
    ex('h2C, 0, 0); ex('h308, 1, 32'hFFFF_8234);
    ex('h30, 0, 0); ex('h34, 0, 0); ex('h200, 0, 0); ex('h200, 1, 32'h1122_3355);
    ex('h38, 0, 0); ex('h40, 0, 0); ex('h44, 0, 0); ex('h54, 0, 0);
    ex('h58, 0, 0); ex('h310, 1, 32'h48);
    ex('h5C, 0, 0); ex('h314, 1, 32'h0);
    ex('h60, 0, 0); ex(32'h1001200c, 1, 32'hFFFF_FFFE);
    ex('h64, 0, 0); ex('h68, 0, 0); ex('h74, 0, 0);
    ex('h78, 0, 0); ex('h318, 1, 32'h64);
    ex('h7C, 0, 0); ex('h31C, 1, 32'h6C);
    ex('h80, 0, 0); ex('h320, 1, 32'h4A);
    ex('h84, 0, 0); ex('h84, 0, 0);

    repeat (3) @(negedge CLK);
    #1;
    chk("rst_rdy_get", {31'b0, RDY_obtain_rq_get}, 32'h0);
    chk("rst_rdy_put", {31'b0, RDY_send_rs_put}, 32'h0);
    chk("rst_pc", dut.proc_m8_pc, 32'h0);
    #1 RST_N = 1'b1;

    wait_drain(4000);
    chk("cyc_alu", acc_cyc[1] - acc_cyc[0], 32'd3);
    chk("cyc_sw_zero_lat", acc_cyc[7] - acc_cyc[5], 32'd4);
    chk("cyc_lb", acc_cyc[9] - acc_cyc[7], 32'd5);
    chk("cyc_sb_rmw", acc_cyc[23] - acc_cyc[20], 32'd7);

    // Abort mid-fetch: the late response must not be taken as an instruction
    for (int c = 0; c < 50; c++) begin
      @(negedge CLK);
      #1;
      if (EN_obtain_rq_get && RDY_obtain_rq_get) break;
    end
    @(posedge CLK);
    #1 RST_N = 1'b0;
    #1;
    chk("mid_rst_rdy_get", {31'b0, RDY_obtain_rq_get}, 32'h0);
    chk("mid_rst_rdy_put", {31'b0, RDY_send_rs_put}, 32'h0);
    chk("mid_rst_pc", dut.proc_m8_pc, 32'h0);
    ex('h00, 0, 0); ex('h04, 0, 0); ex('h08, 0, 0);
    #1 RST_N = 1'b1;
    wait_drain(200);

    $display("== %0d vectors applied, %0d miscompares ==", vecs, miss);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout: got no finish want finish");
    $fatal(1, "timeout");
  end

endmodule
